// File: rtl/tetris_pkg.sv
// Shared board geometry, piece codes, palette colours and draw-sequencer types.
package tetris_pkg;

  localparam int unsigned COLS    = 10;
  localparam int unsigned ROWS    = 20;
  localparam int unsigned CELL_W  = 64;
  localparam int unsigned CELL_H  = 24;

  localparam int unsigned CODE_W  = 3;
  localparam int unsigned COLOR_W = 9;
  localparam int unsigned X_W     = 10;
  localparam int unsigned Y_W     = 9;
  localparam int unsigned ADDR_W  = 8;

  localparam logic [CODE_W-1:0] CODE_EMPTY = 3'd0;
  localparam logic [CODE_W-1:0] CODE_I     = 3'd1;
  localparam logic [CODE_W-1:0] CODE_O     = 3'd2;
  localparam logic [CODE_W-1:0] CODE_T     = 3'd3;
  localparam logic [CODE_W-1:0] CODE_S     = 3'd4;
  localparam logic [CODE_W-1:0] CODE_Z     = 3'd5;
  localparam logic [CODE_W-1:0] CODE_J     = 3'd6;
  localparam logic [CODE_W-1:0] CODE_L     = 3'd7;

  // RRR_GGG_BBB, written in octal so each digit is one channel
  localparam logic [COLOR_W-1:0] COLOR_EMPTY = 9'o000;
  localparam logic [COLOR_W-1:0] COLOR_I     = 9'o077;
  localparam logic [COLOR_W-1:0] COLOR_O     = 9'o770;
  localparam logic [COLOR_W-1:0] COLOR_T     = 9'o507;
  localparam logic [COLOR_W-1:0] COLOR_S     = 9'o070;
  localparam logic [COLOR_W-1:0] COLOR_Z     = 9'o700;
  localparam logic [COLOR_W-1:0] COLOR_J     = 9'o007;
  localparam logic [COLOR_W-1:0] COLOR_L     = 9'o740;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT_RD,
    ST_LAUNCH,
    ST_WAIT_BOX,
    ST_NEXT,
    ST_FIN
  } draw_state_t;

  typedef struct packed {
    logic [X_W-1:0]     x0;
    logic [Y_W-1:0]     y0;
    logic [COLOR_W-1:0] color;
  } box_cmd_t;

endpackage

// File: rtl/piece_palette.sv
// Combinational piece-code to RGB colour lookup.
module piece_palette
  import tetris_pkg::*;
(
  input  logic [CODE_W-1:0]  i_code,
  output logic [COLOR_W-1:0] o_color_c
);

  always_comb begin
    o_color_c = COLOR_EMPTY;
    case (i_code)
      CODE_I:  o_color_c = COLOR_I;
      CODE_O:  o_color_c = COLOR_O;
      CODE_T:  o_color_c = COLOR_T;
      CODE_S:  o_color_c = COLOR_S;
      CODE_Z:  o_color_c = COLOR_Z;
      CODE_J:  o_color_c = COLOR_J;
      CODE_L:  o_color_c = COLOR_L;
      default: o_color_c = COLOR_EMPTY;
    endcase
  end

endmodule

// File: rtl/board_draw_sequencer.sv
// Walks the board RAM in row-major order and issues one box-draw command per cell,
// handshaking each with the box renderer.
module board_draw_sequencer
  import tetris_pkg::*;
#(
  parameter int unsigned COLS       = tetris_pkg::COLS,
  parameter int unsigned ROWS       = tetris_pkg::ROWS,
  parameter int unsigned CELL_W     = tetris_pkg::CELL_W,
  parameter int unsigned CELL_H     = tetris_pkg::CELL_H,
  parameter int unsigned SKIP_EMPTY = 0
)(
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               go,
  output logic [ADDR_W-1:0]  brd_addr,
  input  logic [CODE_W-1:0]  brd_data,
  output logic               box_start,
  output logic [X_W-1:0]     box_x0,
  output logic [Y_W-1:0]     box_y0,
  output logic [COLOR_W-1:0] box_color,
  input  logic               box_done,
  output logic               busy,
  output logic               done
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  draw_state_t        r_state, w_state_nxt;
  logic [COL_W-1:0]   r_col, w_col_nxt;
  logic [ROW_W-1:0]   r_row, w_row_nxt;
  logic [ADDR_W-1:0]  r_cell, w_cell_nxt;
  logic [ADDR_W-1:0]  r_brd_addr, w_brd_addr_nxt;
  box_cmd_t           r_box, w_box_nxt;
  logic               r_rd_wait, w_rd_wait_nxt;
  logic               r_box_start, w_box_start_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [COLOR_W-1:0] w_pal_color_c;
  logic               w_last_col, w_last_row, w_skip;

  piece_palette u_palette (
    .i_code    (brd_data),
    .o_color_c (w_pal_color_c)
  );

  assign w_last_col = (r_col == COL_W'(COLS - 1));
  assign w_last_row = (r_row == ROW_W'(ROWS - 1));
  assign w_skip     = (SKIP_EMPTY != 0) && (brd_data == CODE_EMPTY);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_cell      <= '0;
      r_brd_addr  <= '0;
      r_box       <= '0;
      r_rd_wait   <= 1'b0;
      r_box_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_cell      <= w_cell_nxt;
      r_brd_addr  <= w_brd_addr_nxt;
      r_box       <= w_box_nxt;
      r_rd_wait   <= w_rd_wait_nxt;
      r_box_start <= w_box_start_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next state and datapath; strobes are derived from the state being entered
  always_comb begin
    w_state_nxt    = r_state;
    w_col_nxt      = r_col;
    w_row_nxt      = r_row;
    w_cell_nxt     = r_cell;
    w_brd_addr_nxt = r_brd_addr;
    w_box_nxt      = r_box;
    w_rd_wait_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (go) begin
          w_state_nxt  = ST_RD;
          w_col_nxt    = '0;
          w_row_nxt    = '0;
          w_cell_nxt   = '0;
          w_box_nxt.x0 = '0;
          w_box_nxt.y0 = '0;
        end
      end
      ST_RD: begin
        w_brd_addr_nxt = r_cell;
        w_state_nxt    = ST_WAIT_RD;
      end
      // First cycle lets the RAM see the new address; second captures its data
      ST_WAIT_RD: begin
        if (!r_rd_wait) begin
          w_rd_wait_nxt = 1'b1;
        end else begin
          w_box_nxt.color = w_pal_color_c;
          w_state_nxt     = w_skip ? ST_NEXT : ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        w_state_nxt = ST_WAIT_BOX;
      end
      ST_WAIT_BOX: begin
        if (box_done) begin
          w_state_nxt = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (w_last_col && w_last_row) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_state_nxt = ST_RD;
          w_cell_nxt  = r_cell + ADDR_W'(1);
          if (!w_last_col) begin
            w_col_nxt    = r_col + COL_W'(1);
            w_box_nxt.x0 = r_box.x0 + X_W'(CELL_W);
          end else begin
            w_col_nxt    = '0;
            w_box_nxt.x0 = '0;
            w_row_nxt    = r_row + ROW_W'(1);
            w_box_nxt.y0 = r_box.y0 + Y_W'(CELL_H);
          end
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_box_start_nxt = (w_state_nxt == ST_LAUNCH);
    w_done_nxt      = (w_state_nxt == ST_FIN);
    w_busy_nxt      = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FIN);
  end

  assign brd_addr  = r_brd_addr;
  assign box_start = r_box_start;
  assign box_x0    = r_box.x0;
  assign box_y0    = r_box.y0;
  assign box_color = r_box.color;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/board_draw_sequencer.md
BOARD_DRAW_SEQUENCER -- requirements
Module: board_draw_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- COLS, 10, board columns
- ROWS, 20, board rows
- CELL_W, 64, cell width in pixels
- CELL_H, 24, cell height in pixels
- SKIP_EMPTY, 0, 1 = do not draw cells whose code is 0
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLOCK_50  in  1  sole clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- go  in  1  request one full board redraw; sampled in IDLE only
- brd_addr  out  8  board RAM read address = row*COLS+col
- brd_data  in  3  cell code from synchronous RAM; valid 1 cycle after brd_addr
- box_start  out  1  one-cycle start pulse to the box renderer
- box_x0  out  10  cell top-left X
- box_y0  out  9  cell top-left Y
- box_color  out  9  RRR_GGG_BBB colour
- box_done  in  1  one-cycle completion pulse from the box renderer
- busy  out  1  high from go acceptance until done
- done  out  1  one-cycle pulse after the last cell completes

Function
REQ-003 The FSM SHALL have states IDLE, RD, WAIT_RD, LAUNCH, WAIT_BOX, NEXT and FIN.
REQ-004 IDLE SHALL move to RD when go=1, clearing col, row, box_x0 and box_y0 to 0; go=1 in any other state SHALL be ignored.
REQ-005 RD SHALL drive brd_addr for the current cell and go to WAIT_RD; WAIT_RD SHALL register brd_data and the palette colour on the next edge, then go to LAUNCH.
REQ-006 LAUNCH SHALL assert box_start for exactly one cycle with box_x0, box_y0 and box_color stable, then go to WAIT_BOX.
REQ-007 box_x0, box_y0 and box_color SHALL stay unchanged from LAUNCH until box_done is sampled.
REQ-008 WAIT_BOX SHALL stay until box_done=1, then go to NEXT; box_done in any other state SHALL be ignored.
REQ-009 When SKIP_EMPTY=1 and the latched code is 0, WAIT_RD SHALL go directly to NEXT with no box_start.
REQ-010 NEXT SHALL update position and go to RD:
- if col<COLS-1: col+1, box_x0+=CELL_W
- otherwise: col=0, box_x0=0, row+1, box_y0+=CELL_H
REQ-011 If NEXT is reached with col=COLS-1 and row=ROWS-1, it SHALL go to FIN instead of RD.
REQ-012 FIN SHALL assert done for one cycle and return to IDLE; busy SHALL be 0 in IDLE and FIN and 1 in all other states.
REQ-013 Coordinates SHALL be formed by accumulating, not multiplying; the maxima 576 (10 bits) and 456 (9 bits) SHALL never wrap.
REQ-014 brd_addr SHALL equal row*COLS+col, range 0..199, with row-major scan order.
REQ-015 The palette SHALL map codes as follows: 0=000, 1=I 077, 2=O 770, 3=T 507, 4=S 070, 5=Z 700, 6=J 007, 7=L 740 (octal RGB).
REQ-016 A draw with SKIP_EMPTY=0 SHALL issue exactly COLS*ROWS box_start pulses.

Reset
REQ-017 resetn=0 SHALL immediately force the following, at any time including mid-draw: state=IDLE, col=row=0, box_start=0, busy=0, done=0, box_x0=0, box_y0=0, box_color=0, brd_addr=0.
REQ-018 After reset release, the block SHALL issue no box_start until a new go is received.

Structure
REQ-019 The shared package tetris_pkg SHALL hold: COLS, ROWS, CELL_W, CELL_H, the 3-bit piece-code constants, and the 9-bit palette constants.
REQ-020 Colour lookup SHALL be a combinational sub-module piece_palette (3-bit code in, 9-bit colour out); the FSM, counters and accumulators SHALL stay in board_draw_sequencer.

Verification
REQ-021 The bench SHALL model the renderer as box_done asserted 5 cycles after each box_start, and SHALL cover these directed scenarios:
- Board all zeros, SKIP_EMPTY=0, go -> 200 box_start pulses, all with colour 000; the last has x0=576, y0=456; one done pulse; busy falls with done.
- Board all zeros, SKIP_EMPTY=1, go -> no box_start; done exactly 200*4 cycles after go acceptance.
- Cell 13=3 and cell 199=7, SKIP_EMPTY=1 -> exactly two starts: (x0=192, y0=24, colour 507), then (576, 456, 740).
- go pulsed repeatedly during busy -> still exactly one pass of 200 starts and one done.
- box_done injected during WAIT_RD -> ignored; no skipped cell and no early advance.
- resetn low while in WAIT_BOX at cell 50 -> all outputs zero at once; after release, no box_start until go; the next go restarts at cell 0.
